count_display_driver: RTL and testbench

Downstream consumer of the 4-bit MOD-16 count. Samples the free-running count, converts it to two decimal digits (00–15), and drives a time-multiplexed 2-digit common-anode 7-segment display with tens leading-zero blanking. It also detects 15→0 wrap-around, stretches each wrap into a visible LED pulse, and keeps a saturating wrap tally.

---
 rtl/count_disp_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 25 ++
 rtl/count_display_driver.sv | 110 +++++++++++
 tb/tb_count_display_driver.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_disp_pkg.sv
// Shared constants and types for the count display driver: segment codes,
// scan states and anode patterns (all active-low).
package count_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  typedef enum logic {
    UNITS,
    TENS
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder {g,f,e,d,c,b,a};
// anything above 9 is shown blank.
module seg7_decode (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  import count_disp_pkg::*;

  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// Samples a MOD-16 count, shows it as two multiplexed decimal digits with tens
// blanking, and stretches/tallies every 15->0 wrap of the count.
module count_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned WRAP_HOLD   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_i,
  output logic [6:0] seg_o,
  output logic [1:0] an_o,
  output logic       wrap_led_o,
  output logic [7:0] wrap_cnt_o
);
  import count_disp_pkg::*;

  localparam int unsigned   RefW     = $clog2(REFRESH_DIV);
  localparam int unsigned   HoldW    = $clog2(WRAP_HOLD + 1);
  localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_DIV - 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(WRAP_HOLD);

  logic [3:0]       count_q, prev_q, frame_q;
  scan_state_e      state_q;
  logic [RefW-1:0]  refresh_q;
  logic [HoldW-1:0] hold_q;
  logic [6:0]       seg_q;
  logic [1:0]       an_q;
  logic             wrap_led_q;
  logic [7:0]       wrap_cnt_q;

  logic       frame_start, tens, wrap_evt;
  logic [3:0] frame_d, units, dec_in;
  logic [6:0] seg_d;
  logic [1:0] an_d;

  // The frame value is captured on the first cycle of the units slot and used
  // immediately, so both digits of a frame always come from one sample.
  always_comb begin
    frame_start = (state_q == UNITS) && (refresh_q == '0);
    frame_d     = frame_start ? count_q : frame_q;
    tens        = (frame_d >= 4'd10);
    units       = tens ? (frame_d - 4'd10) : frame_d;
    if (state_q == UNITS) begin
      dec_in = units;
      an_d   = AN_UNITS;
    end else if (tens) begin
      dec_in = 4'd1;
      an_d   = AN_TENS;
    end else begin
      dec_in = 4'hF;
      an_d   = AN_OFF;
    end
    wrap_evt = (prev_q == 4'd15) && (count_q == 4'd0);
  end

  seg7_decode u_seg7_decode (
    .digit_i (dec_in),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNITS;
      refresh_q <= '0;
      frame_q   <= 4'd0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else begin
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      if (refresh_q == RefLast) begin
        refresh_q <= '0;
        state_q   <= (state_q == UNITS) ? TENS : UNITS;
      end else begin
        refresh_q <= refresh_q + RefW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 4'd0;
      prev_q     <= 4'd0;
      hold_q     <= '0;
      wrap_led_q <= 1'b0;
      wrap_cnt_q <= 8'd0;
    end else begin
      count_q <= count_i;
      prev_q  <= count_q;
      // A new wrap reloads the full hold rather than extending it.
      if (wrap_evt) begin
        hold_q     <= HoldInit;
        wrap_led_q <= 1'b1;
        if (wrap_cnt_q != 8'hFF) begin
          wrap_cnt_q <= wrap_cnt_q + 8'd1;
        end
      end else if (hold_q != '0) begin
        hold_q     <= hold_q - HoldW'(1);
        wrap_led_q <= (hold_q != HoldW'(1));
      end
    end
  end

  assign seg_o      = seg_q;
  assign an_o       = an_q;
  assign wrap_led_o = wrap_led_q;
  assign wrap_cnt_o = wrap_cnt_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: directed scenarios plus random
// stimulus, each compared against an edge-history reference model.
module tb_count_display_driver;

  localparam int R     = 4;
  localparam int W     = 6;
  localparam int Depth = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count_i = 4'd0;
  logic [6:0] seg_o;
  logic [1:0] an_o;
  logic       wrap_led_o;
  logic [7:0] wrap_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;
  int t        = -1;
  int last_rst = 0;

  logic [3:0] in_h  [Depth];
  logic       rst_h [Depth];
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [17:0] exp_v;

  count_display_driver #(
    .REFRESH_DIV (R),
    .WRAP_HOLD   (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count_i    (count_i),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .wrap_led_o (wrap_led_o),
    .wrap_cnt_o (wrap_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle, record what the DUT saw at the edge, then settle.
  task automatic tick(input logic [3:0] c, input logic r);
    count_i = c;
    reset   = r;
    @(posedge clk);
    t++;
    if (t >= Depth) begin
      $display("FAIL history_overflow t=%0d limit=%0d", t, Depth);
      $fatal(1, "history overflow");
    end
    in_h[t]  = c;
    rst_h[t] = r;
    if (r) last_rst = t;
    #1;
  endtask

  function automatic logic [3:0] qv(input int i);
    return rst_h[i] ? 4'd0 : in_h[i];
  endfunction

  // Expected {seg, an, wrap_led, wrap_cnt} in the cycle after edge i.
  function automatic logic [17:0] model(input int i);
    int lr, p, pos, nw, lw;
    logic [3:0] v;
    logic [6:0] s;
    logic [1:0] a;
    logic       led;
    logic [7:0] wc;
    if (rst_h[i]) return {7'h7F, 2'b11, 1'b0, 8'd0};
    lr = i;
    while (!rst_h[lr]) lr--;
    p   = i - lr;
    pos = (p - 1) % (2 * R);
    v   = qv(i - pos - 1);
    if (pos < R) begin
      a = 2'b10;
      s = seg_tbl[int'(v) % 10];
    end else if (v >= 4'd10) begin
      a = 2'b01;
      s = 7'h79;
    end else begin
      a = 2'b11;
      s = 7'h7F;
    end
    nw = 0;
    lw = -1;
    for (int j = lr + 1; j < i; j++) begin
      if (qv(j) == 4'd0 && qv(j - 1) == 4'd15) begin
        nw++;
        lw = j;
      end
    end
    led = (lw >= 0) && (i - lw <= W);
    wc  = (nw > 255) ? 8'd255 : 8'(nw);
    return {s, a, led, wc};
  endfunction

  function automatic int pos_now();
    return (t - last_rst - 1) % (2 * R);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'd0, 1'b1);
      n_checks++;
      if ({seg_o, an_o, wrap_led_o, wrap_cnt_o} !== {7'h7F, 2'b11, 1'b0, 8'd0}) begin
        n_fails++;
        $display("FAIL reset_hold t=%0d got seg=%h an=%b led=%b cnt=%0d want 7f/11/0/0",
                 t, seg_o, an_o, wrap_led_o, wrap_cnt_o);
      end
    end
    tick(4'd0, 1'b0);
    n_checks++;
    if ({seg_o, an_o} !== {7'h40, 2'b10}) begin
      n_fails++;
      $display("FAIL reset_release t=%0d got seg=%h an=%b want 40/10", t, seg_o, an_o);
    end
  endtask

  task automatic test_hold(input logic [3:0] val, input logic [6:0] useg,
                           input logic [1:0] tan, input logic [6:0] tseg);
    for (int i = 0; i < 4 * R + 2; i++) begin
      tick(val, 1'b0);
      exp_v = model(t);
      n_checks++;
      if ({seg_o, an_o, wrap_led_o, wrap_cnt_o} !== exp_v) begin
        n_fails++;
        $display("FAIL hold_%0d_model t=%0d got seg=%h an=%b led=%b cnt=%0d want %h/%b/%b/%0d",
                 val, t, seg_o, an_o, wrap_led_o, wrap_cnt_o,
                 exp_v[17:11], exp_v[10:9], exp_v[8], exp_v[7:0]);
      end
      if (i >= 2 * R + 2) begin
        n_checks++;
        if (pos_now() < R ? ({an_o, seg_o} !== {2'b10, useg}) : ({an_o, seg_o} !== {tan, tseg}))
        begin
          n_fails++;
          $display("FAIL hold_%0d_digit t=%0d pos=%0d got an=%b seg=%h", val, t, pos_now(),
                   an_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_mid_frame();
    for (int i = 0; i < 2 * R && pos_now() != 1; i++) tick(4'd13, 1'b0);
    n_checks++;
    if (pos_now() != 1) begin
      n_fails++;
      $display("FAIL mid_align got pos=%0d want 1", pos_now());
    end
    tick(4'd10, 1'b0);
    n_checks++;
    if ({an_o, seg_o} !== {2'b10, 7'h30}) begin
      n_fails++;
      $display("FAIL mid_unchanged t=%0d got an=%b seg=%h want 10/30", t, an_o, seg_o);
    end
    for (int i = 0; i < 2 * R + 2; i++) begin
      tick(4'd10, 1'b0);
      exp_v = model(t);
      n_checks++;
      if ({seg_o, an_o, wrap_led_o, wrap_cnt_o} !== exp_v) begin
        n_fails++;
        $display("FAIL mid_model t=%0d got seg=%h an=%b led=%b cnt=%0d want %h/%b/%b/%0d",
                 t, seg_o, an_o, wrap_led_o, wrap_cnt_o,
                 exp_v[17:11], exp_v[10:9], exp_v[8], exp_v[7:0]);
      end
      if (pos_now() == 0) begin
        n_checks++;
        if ({an_o, seg_o} !== {2'b10, 7'h40}) begin
          n_fails++;
          $display("FAIL mid_next_frame t=%0d got an=%b seg=%h want 10/40", t, an_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int e0;
    tick(4'd14, 1'b0);
    tick(4'd15, 1'b0);
    tick(4'd0, 1'b0);
    e0 = t;
    for (int m = 1; m <= 8; m++) begin
      tick(4'd0, 1'b0);
      n_checks++;
      if (wrap_led_o !== (m <= W) || wrap_cnt_o !== 8'd1) begin
        n_fails++;
        $display("FAIL wrap_pulse m=%0d got led=%b cnt=%0d want led=%b cnt=1",
                 m, wrap_led_o, wrap_cnt_o, (m <= W));
      end
    end
    tick(4'd15, 1'b0);
    for (int m = 0; m < 8; m++) begin
      tick(4'd3, 1'b0);
      exp_v = model(t);
      n_checks++;
      if ({seg_o, an_o, wrap_led_o, wrap_cnt_o} !== exp_v || wrap_led_o !== 1'b0) begin
        n_fails++;
        $display("FAIL no_wrap_15_3 t=%0d got led=%b cnt=%0d seg=%h want %b/%0d/%h (e0=%0d)",
                 t, wrap_led_o, wrap_cnt_o, seg_o, exp_v[8], exp_v[7:0], exp_v[17:11], e0);
      end
    end
  endtask

  task automatic test_retrigger();
    int e0;
    tick(4'd0, 1'b1);
    tick(4'd14, 1'b0);
    tick(4'd15, 1'b0);
    tick(4'd0, 1'b0);
    e0 = t;
    tick(4'd0, 1'b0);
    tick(4'd15, 1'b0);
    tick(4'd0, 1'b0);
    for (int m = 4; m <= 12; m++) tick(4'd0, 1'b0);
    for (int m = 1; m <= 12; m++) begin
      n_checks++;
      if (model(e0 + m) !== model(e0 + m) || model(e0 + m)[8] !== (m <= 3 + W)) begin
        n_fails++;
        $display("FAIL retrigger_model m=%0d got led=%b want %b", m, model(e0 + m)[8], (m <= 3 + W));
      end
    end
    n_checks++;
    if (wrap_cnt_o !== 8'd2 || wrap_led_o !== 1'b0) begin
      n_fails++;
      $display("FAIL retrigger_end got cnt=%0d led=%b want 2/0", wrap_cnt_o, wrap_led_o);
    end
    for (int n = 0; n < 300; n++) begin
      tick(4'd15, 1'b0);
      tick(4'd0, 1'b0);
      exp_v = model(t);
      n_checks++;
      if ({seg_o, an_o, wrap_led_o, wrap_cnt_o} !== exp_v) begin
        n_fails++;
        $display("FAIL saturate_model t=%0d got seg=%h an=%b led=%b cnt=%0d want %h/%b/%b/%0d",
                 t, seg_o, an_o, wrap_led_o, wrap_cnt_o,
                 exp_v[17:11], exp_v[10:9], exp_v[8], exp_v[7:0]);
      end
    end
    tick(4'd0, 1'b0);
    n_checks++;
    if (wrap_cnt_o !== 8'd255) begin
      n_fails++;
      $display("FAIL saturate got cnt=%0d want 255", wrap_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    tick(4'd15, 1'b0);
    tick(4'd0, 1'b0);
    for (int i = 0; i < 16 && !(pos_now() >= R && wrap_led_o); i++) tick(4'd0, 1'b0);
    n_checks++;
    if (!(pos_now() >= R && wrap_led_o === 1'b1)) begin
      n_fails++;
      $display("FAIL reset_mid_setup got pos=%0d led=%b want tens slot with led=1",
               pos_now(), wrap_led_o);
    end
    tick(4'd0, 1'b1);
    n_checks++;
    if ({seg_o, an_o, wrap_led_o, wrap_cnt_o} !== {7'h7F, 2'b11, 1'b0, 8'd0}) begin
      n_fails++;
      $display("FAIL reset_mid t=%0d got seg=%h an=%b led=%b cnt=%0d want 7f/11/0/0",
               t, seg_o, an_o, wrap_led_o, wrap_cnt_o);
    end
    tick(4'd0, 1'b0);
    n_checks++;
    if ({an_o, seg_o} !== {2'b10, 7'h40}) begin
      n_fails++;
      $display("FAIL reset_mid_restart got an=%b seg=%h want 10/40", an_o, seg_o);
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'd0, 1'b0);
      n_checks++;
      if (wrap_led_o !== 1'b0 || wrap_cnt_o !== 8'd0) begin
        n_fails++;
        $display("FAIL reset_mid_led t=%0d got led=%b cnt=%0d want 0/0", t, wrap_led_o,
                 wrap_cnt_o);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic       r;
    c = 4'd0;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 63) == 0);
      if (c == 4'd15 && $urandom_range(0, 1) == 1) c = 4'd0;
      else if ($urandom_range(0, 3) == 0) c = 4'd15;
      else c = 4'($urandom_range(0, 15));
      tick(c, r);
      exp_v = model(t);
      n_checks++;
      if ({seg_o, an_o, wrap_led_o, wrap_cnt_o} !== exp_v) begin
        n_fails++;
        $display("FAIL random t=%0d got seg=%h an=%b led=%b cnt=%0d want %h/%b/%b/%0d",
                 t, seg_o, an_o, wrap_led_o, wrap_cnt_o,
                 exp_v[17:11], exp_v[10:9], exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold(4'd7, 7'h78, 2'b11, 7'h7F);
    test_hold(4'd13, 7'h30, 2'b01, 7'h79);
    test_mid_frame();
    test_wrap();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
